// File: rtl/rs_mul_pkg.sv
// Shared types for the multiply reservation station: operand/packet layouts,
// multiply function encoding and the CDB operand-capture helper.
package rs_mul_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PRF_LEN = 6;
    localparam int unsigned ROB_LEN = 5;

    typedef enum logic [1:0] {
        ALU_MUL    = 2'd0,
        ALU_MULH   = 2'd1,
        ALU_MULHSU = 2'd2,
        ALU_MULHU  = 2'd3
    } MUL_FUNC;

    typedef struct packed {
        logic               opa_ready;
        logic [XLEN-1:0]    opa_value;
        logic [PRF_LEN-1:0] opa_preg_idx;
        logic               opb_ready;
        logic [XLEN-1:0]    opb_value;
        logic [PRF_LEN-1:0] opb_preg_idx;
        MUL_FUNC            mul_func;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } RS_MUL_DISPATCH_PACKET;

    typedef struct packed {
        logic [XLEN-1:0]    opa_value;
        logic [XLEN-1:0]    opb_value;
        MUL_FUNC            mul_func;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } RS_MUL_PACKET;

    typedef struct packed {
        logic                  valid;
        RS_MUL_DISPATCH_PACKET op;
    } RS_MUL_ENTRY;

    // Capture a CDB broadcast into any still-waiting operand whose tag matches.
    function automatic RS_MUL_DISPATCH_PACKET wake_op(
        input RS_MUL_DISPATCH_PACKET op,
        input logic                  bc_valid,
        input logic [PRF_LEN-1:0]    bc_tag,
        input logic [XLEN-1:0]       bc_value
    );
        RS_MUL_DISPATCH_PACKET res;
        res = op;
        if (bc_valid && !op.opa_ready && (op.opa_preg_idx == bc_tag)) begin
            res.opa_ready = 1'b1;
            res.opa_value = bc_value;
        end
        if (bc_valid && !op.opb_ready && (op.opb_preg_idx == bc_tag)) begin
            res.opb_ready = 1'b1;
            res.opb_value = bc_value;
        end
        return res;
    endfunction

    function automatic RS_MUL_PACKET to_issue_packet(input RS_MUL_DISPATCH_PACKET op);
        RS_MUL_PACKET pkt;
        pkt.opa_value     = op.opa_value;
        pkt.opb_value     = op.opb_value;
        pkt.mul_func      = op.mul_func;
        pkt.dest_preg_idx = op.dest_preg_idx;
        pkt.rob_idx       = op.rob_idx;
        pkt.PC            = op.PC;
        return pkt;
    endfunction

endpackage

// File: rtl/rs_mul_psel.sv
// Lowest-index priority selector: one-hot grant of the lowest set request bit.
module rs_mul_psel #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             valid
);

    // Isolate the lowest set bit (two's-complement trick).
    always_comb begin
        gnt   = req & (~req + WIDTH'(1));
        valid = |req;
    end

endmodule

// File: rtl/rs_mul.sv
// Reservation station for the pipelined multiplier. Buffers dispatched ops,
// wakes operands from the CDB, and issues one ready op at a time into a held
// packet that stays stable until the next issue.
module rs_mul
    import rs_mul_pkg::*;
#(
    parameter int unsigned RS_MUL_SIZE = 4,
    parameter int unsigned RS_MUL_LEN  = $clog2(RS_MUL_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dispatch_enable,
    input  RS_MUL_DISPATCH_PACKET dispatch_packet,
    input  logic                  cdb_broadcast_valid,
    input  logic [PRF_LEN-1:0]    cdb_dest_preg_idx,
    input  logic [XLEN-1:0]       cdb_value,
    input  logic                  squash,
    input  logic                  mul_free,
    output RS_MUL_PACKET          rs_mul_packet,
    output logic                  mul_enable,
    output logic                  rs_mul_full
);

    RS_MUL_ENTRY entries_q [RS_MUL_SIZE];
    RS_MUL_ENTRY entries_d [RS_MUL_SIZE];

    logic [RS_MUL_SIZE-1:0] valid_vec;
    logic [RS_MUL_SIZE-1:0] ready_vec;
    logic [RS_MUL_SIZE-1:0] alloc_gnt;
    logic [RS_MUL_SIZE-1:0] issue_gnt;
    logic                   alloc_valid;
    logic                   issue_valid;
    logic [RS_MUL_LEN-1:0]  alloc_idx;
    logic [RS_MUL_LEN-1:0]  issue_idx;
    logic                   dispatch_fire;
    logic                   issue_fire;
    RS_MUL_DISPATCH_PACKET  dispatch_op;
    RS_MUL_PACKET           issue_pkt;

    // Occupancy and readiness vectors from registered entry state.
    always_comb begin
        for (int i = 0; i < RS_MUL_SIZE; i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid && entries_q[i].op.opa_ready
                           && entries_q[i].op.opb_ready;
        end
        rs_mul_full = &valid_vec;
    end

    rs_mul_psel #(
        .WIDTH (RS_MUL_SIZE)
    ) u_alloc_sel (
        .req   (~valid_vec),
        .gnt   (alloc_gnt),
        .valid (alloc_valid)
    );

    rs_mul_psel #(
        .WIDTH (RS_MUL_SIZE)
    ) u_issue_sel (
        .req   (ready_vec),
        .gnt   (issue_gnt),
        .valid (issue_valid)
    );

    // Encode one-hot grants to indices and pick the issue candidate's fields.
    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        for (int i = 0; i < RS_MUL_SIZE; i++) begin
            if (alloc_gnt[i]) alloc_idx = RS_MUL_LEN'(i);
            if (issue_gnt[i]) issue_idx = RS_MUL_LEN'(i);
        end
        issue_pkt = to_issue_packet(entries_q[issue_idx].op);
        // mul_enable still high means the multiplier has not yet dropped mul_free.
        issue_fire    = mul_free && !mul_enable && issue_valid && !squash;
        dispatch_fire = dispatch_enable && !rs_mul_full && alloc_valid && !squash;
    end

    // Next entry state: wakeup, issue release, dispatch write, squash flush.
    always_comb begin
        dispatch_op = wake_op(dispatch_packet, cdb_broadcast_valid, cdb_dest_preg_idx,
                              cdb_value);
        for (int i = 0; i < RS_MUL_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                entries_d[i].op = wake_op(entries_q[i].op, cdb_broadcast_valid,
                                          cdb_dest_preg_idx, cdb_value);
            end
            if (issue_fire && (issue_idx == RS_MUL_LEN'(i))) begin
                entries_d[i].valid = 1'b0;
            end
            if (dispatch_fire && (alloc_idx == RS_MUL_LEN'(i))) begin
                entries_d[i].valid = 1'b1;
                entries_d[i].op    = dispatch_op;
            end
            if (squash) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    // Entry array register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_MUL_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_MUL_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Issue strobe and held packet; the packet only moves on an issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_enable             <= 1'b0;
            rs_mul_packet          <= '0;
            rs_mul_packet.mul_func <= ALU_MUL;
        end else begin
            mul_enable <= issue_fire;
            if (issue_fire) begin
                rs_mul_packet <= issue_pkt;
            end
        end
    end

endmodule

// File: tb/tb_rs_mul.sv
// Bench for rs_mul: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the reservation station.
module tb_rs_mul;
    import rs_mul_pkg::*;

    localparam int N = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  dispatch_enable;
    RS_MUL_DISPATCH_PACKET dispatch_packet;
    logic                  cdb_broadcast_valid;
    logic [PRF_LEN-1:0]    cdb_dest_preg_idx;
    logic [XLEN-1:0]       cdb_value;
    logic                  squash;
    logic                  mul_free;
    RS_MUL_PACKET          rs_mul_packet;
    logic                  mul_enable;
    logic                  rs_mul_full;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    RS_MUL_DISPATCH_PACKET m_op [N];
    bit                    m_valid [N];
    bit                    m_en;
    RS_MUL_PACKET          m_pkt;

    rs_mul #(
        .RS_MUL_SIZE (N)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .dispatch_enable     (dispatch_enable),
        .dispatch_packet     (dispatch_packet),
        .cdb_broadcast_valid (cdb_broadcast_valid),
        .cdb_dest_preg_idx   (cdb_dest_preg_idx),
        .cdb_value           (cdb_value),
        .squash              (squash),
        .mul_free            (mul_free),
        .rs_mul_packet       (rs_mul_packet),
        .mul_enable          (mul_enable),
        .rs_mul_full         (rs_mul_full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // An operand waiting on a tag takes the broadcast value when the tag matches.
    function automatic RS_MUL_DISPATCH_PACKET snoop(input RS_MUL_DISPATCH_PACKET op);
        RS_MUL_DISPATCH_PACKET r = op;
        if (cdb_broadcast_valid) begin
            if (!r.opa_ready && r.opa_preg_idx == cdb_dest_preg_idx) begin
                r.opa_ready = 1'b1;
                r.opa_value = cdb_value;
            end
            if (!r.opb_ready && r.opb_preg_idx == cdb_dest_preg_idx) begin
                r.opb_ready = 1'b1;
                r.opb_value = cdb_value;
            end
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit full;
        int cand;
        int slot;
        bit do_issue;
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_en  = 1'b0;
            m_pkt = '0;
            return;
        end
        full = 1'b1;
        cand = -1;
        slot = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_valid[i]) full = 1'b0;
            if (cand < 0 && m_valid[i] && m_op[i].opa_ready && m_op[i].opb_ready) cand = i;
            if (slot < 0 && !m_valid[i]) slot = i;
        end
        do_issue = mul_free && !m_en && (cand >= 0) && !squash;
        if (do_issue) begin
            m_pkt.opa_value     = m_op[cand].opa_value;
            m_pkt.opb_value     = m_op[cand].opb_value;
            m_pkt.mul_func      = m_op[cand].mul_func;
            m_pkt.dest_preg_idx = m_op[cand].dest_preg_idx;
            m_pkt.rob_idx       = m_op[cand].rob_idx;
            m_pkt.PC            = m_op[cand].PC;
            m_valid[cand]       = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) m_op[i] = snoop(m_op[i]);
        end
        if (dispatch_enable && !full && !squash) begin
            m_op[slot]    = snoop(dispatch_packet);
            m_valid[slot] = 1'b1;
        end
        if (squash) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end
        m_en = do_issue;
    endtask

    // One clock: let the edge happen, update the model, compare all outputs.
    task automatic step();
        bit exp_full;
        @(posedge clock);
        #1;
        model_edge();
        exp_full = 1'b1;
        foreach (m_valid[i]) if (!m_valid[i]) exp_full = 1'b0;
        check("mul_enable", 128'(mul_enable), 128'(m_en));
        check("rs_mul_full", 128'(rs_mul_full), 128'(exp_full));
        check("rs_mul_packet", 128'(rs_mul_packet), 128'(m_pkt));
    endtask

    task automatic idle_inputs();
        dispatch_enable     = 1'b0;
        dispatch_packet     = '0;
        cdb_broadcast_valid = 1'b0;
        cdb_dest_preg_idx   = '0;
        cdb_value           = '0;
        squash              = 1'b0;
    endtask

    function automatic RS_MUL_DISPATCH_PACKET mk_op(
        input bit a_rdy, input logic [XLEN-1:0] a_val, input int a_tag,
        input bit b_rdy, input logic [XLEN-1:0] b_val, input int b_tag,
        input MUL_FUNC f, input int dest
    );
        RS_MUL_DISPATCH_PACKET p;
        p.opa_ready     = a_rdy;
        p.opa_value     = a_val;
        p.opa_preg_idx  = PRF_LEN'(a_tag);
        p.opb_ready     = b_rdy;
        p.opb_value     = b_val;
        p.opb_preg_idx  = PRF_LEN'(b_tag);
        p.mul_func      = f;
        p.dest_preg_idx = PRF_LEN'(dest);
        p.rob_idx       = ROB_LEN'(dest);
        p.PC            = XLEN'(32'h1000 + dest * 4);
        return p;
    endfunction

    function automatic RS_MUL_DISPATCH_PACKET rand_op();
        RS_MUL_DISPATCH_PACKET p;
        p.opa_ready     = ($urandom_range(0, 2) != 0);
        p.opa_value     = $urandom;
        p.opa_preg_idx  = PRF_LEN'($urandom_range(0, 7));
        p.opb_ready     = ($urandom_range(0, 2) != 0);
        p.opb_value     = $urandom;
        p.opb_preg_idx  = PRF_LEN'($urandom_range(0, 7));
        p.mul_func      = MUL_FUNC'($urandom_range(0, 3));
        p.dest_preg_idx = PRF_LEN'($urandom);
        p.rob_idx       = ROB_LEN'($urandom);
        p.PC            = $urandom;
        return p;
    endfunction

    initial begin
        RS_MUL_PACKET held;
        idle_inputs();
        mul_free = 1'b1;
        reset    = 1'b1;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_en  = 1'b0;
        m_pkt = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_en", 128'(mul_enable), 128'(0));
        check("reset_full", 128'(rs_mul_full), 128'(0));
        check("reset_pkt", 128'(rs_mul_packet), 128'(0));

        // 1: ready MUL 3*5 issues with mul_enable in cycle 2
        dispatch_enable = 1'b1;
        dispatch_packet = mk_op(1, 3, 1, 1, 5, 2, ALU_MUL, 10);
        step();
        idle_inputs();
        check("t1_no_bypass", 128'(mul_enable), 128'(0));
        step();
        check("t1_issue", 128'(mul_enable), 128'(1));
        check("t1_opa", 128'(rs_mul_packet.opa_value), 128'(3));
        check("t1_opb", 128'(rs_mul_packet.opb_value), 128'(5));
        check("t1_func", 128'(rs_mul_packet.mul_func), 128'(ALU_MUL));
        step();
        check("t1_pulse", 128'(mul_enable), 128'(0));

        // 2: MULH waits on opb tag 7, woken two cycles later
        dispatch_enable = 1'b1;
        dispatch_packet = mk_op(1, 2, 1, 0, 0, 7, ALU_MULH, 11);
        step();
        idle_inputs();
        step();
        cdb_broadcast_valid = 1'b1;
        cdb_dest_preg_idx   = PRF_LEN'(7);
        cdb_value           = 32'hFFFF_FFFE;
        step();
        idle_inputs();
        check("t2_wait", 128'(mul_enable), 128'(0));
        step();
        check("t2_issue", 128'(mul_enable), 128'(1));
        check("t2_opb", 128'(rs_mul_packet.opb_value), 128'(32'hFFFF_FFFE));

        // 3: wakeup of the dispatching op itself
        dispatch_enable     = 1'b1;
        dispatch_packet     = mk_op(0, 0, 9, 1, 4, 3, ALU_MULHU, 12);
        cdb_broadcast_valid = 1'b1;
        cdb_dest_preg_idx   = PRF_LEN'(9);
        cdb_value           = 32'd11;
        step();
        idle_inputs();
        step();
        check("t3_issue", 128'(mul_enable), 128'(1));
        check("t3_opa", 128'(rs_mul_packet.opa_value), 128'(11));
        step();

        // 4: fill with multiplier busy, overflow dispatch ignored, then drain one
        mul_free = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dispatch_enable = 1'b1;
            dispatch_packet = mk_op(1, 100 + i, 1, 1, 200 + i, 2, ALU_MULHSU, 20 + i);
            step();
        end
        idle_inputs();
        check("t4_full", 128'(rs_mul_full), 128'(1));
        held     = rs_mul_packet;
        mul_free = 1'b1;
        step();
        mul_free = 1'b0;
        check("t4_full_drop", 128'(rs_mul_full), 128'(0));
        check("t4_entry0", 128'(rs_mul_packet.opa_value), 128'(100));
        held = rs_mul_packet;
        step();
        step();
        check("t4_hold", 128'(rs_mul_packet), 128'(held));

        // 6: squash with concurrent dispatch flushes everything
        held            = rs_mul_packet;
        squash          = 1'b1;
        dispatch_enable = 1'b1;
        dispatch_packet = mk_op(1, 1, 1, 1, 1, 1, ALU_MUL, 30);
        mul_free        = 1'b1;
        step();
        idle_inputs();
        check("t6_full", 128'(rs_mul_full), 128'(0));
        check("t6_en", 128'(mul_enable), 128'(0));
        check("t6_pkt", 128'(rs_mul_packet), 128'(held));
        step();
        check("t6_empty", 128'(mul_enable), 128'(0));

        // Random traffic, alternating busy and free multiplier phases
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int free_pct;
            free_pct            = ((cyc / 150) % 2 == 0) ? 15 : 90;
            mul_free            = ($urandom_range(0, 99) < free_pct);
            dispatch_enable     = ($urandom_range(0, 99) < 60);
            dispatch_packet     = rand_op();
            cdb_broadcast_valid = ($urandom_range(0, 99) < 50);
            cdb_dest_preg_idx   = PRF_LEN'($urandom_range(0, 7));
            cdb_value           = $urandom;
            squash              = ($urandom_range(0, 99) < 3);
            reset               = ($urandom_range(0, 999) < 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_mul.md
Name: rs_mul

Overview:
- Reservation station for the pipelined multiply unit; sits between dispatch and the multiply-to-CDB stage.
- Buffers dispatched MUL/MULH/MULHSU/MULHU ops and captures source operands from CDB broadcasts.
- Issues one ready op at a time when the multiplier reports free.
- Holds the issued packet stable on its output until the next issue, because the multiplier reads operand signs and func combinationally at completion.

Parameters:
- RS_MUL_SIZE, 4, number of entries (power of 2, >=2)
- RS_MUL_LEN, $clog2(RS_MUL_SIZE), entry index width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_enable  in  1  write a new op this cycle
- dispatch_packet  in  RS_MUL_DISPATCH_PACKET  op fields:
  - opa_ready, opa_value, opa_preg_idx; opb_ready, opb_value, opb_preg_idx
  - mul_func, dest_preg_idx, rob_idx, PC
- cdb_broadcast_valid  in  1  CDB result valid
- cdb_dest_preg_idx  in  PRF_LEN  tag of the broadcast result
- cdb_value  in  XLEN  broadcast value
- squash  in  1  branch-mispredict flush
- mul_free  in  1  multiplier idle (from the multiply-to-CDB stage)
- rs_mul_packet  out  RS_MUL_PACKET  held issue packet: opa_value, opb_value, mul_func, dest_preg_idx, rob_idx, PC
- mul_enable  out  1  one-cycle issue strobe
- rs_mul_full  out  1  all entries valid

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high.
- Reset:
  - All entry valid bits = 0; mul_enable = 0; rs_mul_full = 0.
  - rs_mul_packet = all zeros, with mul_func = ALU_MUL.
- Entry state: valid, opa_ready, opb_ready, opa_value/tag, opb_value/tag, mul_func, dest_preg_idx, rob_idx, PC.
- Full flag: rs_mul_full = AND of the current valid bits (combinational from registered state).
- Dispatch:
  - When dispatch_enable && !rs_mul_full, write the lowest-index free entry at the clock edge.
  - Dispatch while full is ignored; the entry array is unchanged.
  - An entry freed by issue in the same cycle does not lift full for that cycle.
- Wakeup:
  - Every cycle, each valid entry with an unready operand whose tag == cdb_dest_preg_idx and cdb_broadcast_valid set: ready <= 1, value <= cdb_value.
  - The same comparison applies to the dispatching op's unready operands in the same cycle; it is captured ready with the CDB value.
  - Both operands may wake on one broadcast when their tags are equal.
- Issue select:
  - Candidate = lowest-index entry with valid && opa_ready && opb_ready.
  - Issue condition = mul_free && !mul_enable && candidate exists && !squash.
  - On issue at edge t: rs_mul_packet <= candidate fields; candidate valid <= 0; mul_enable = 1 during cycle t+1 only.
- mul_enable gating: mul_enable blocks back-to-back issue, because mul_free only drops the cycle after the multiplier samples mul_enable.
- Packet hold: rs_mul_packet changes only on issue; otherwise it holds its value.
- Latency: an op dispatched with both operands ready in cycle 0 drives mul_enable in cycle 2 (minimum); there is no dispatch-to-issue bypass.
- Squash:
  - Next edge: all valid = 0, mul_enable = 0.
  - Concurrent dispatch and issue are dropped.
  - rs_mul_packet holds its value; an in-flight multiply is not killed here.
- Reset mid-operation: reset overrides dispatch, wakeup, issue and squash; state returns to reset values at the next edge.
- Widths: values are XLEN and tags are PRF_LEN; no arithmetic is done here.

Decomposition:
- Shared package holds:
  - RS_MUL_DISPATCH_PACKET and RS_MUL_PACKET typedefs.
  - MUL_FUNC enum: ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
  - XLEN, PRF_LEN, ROB_LEN.
- Sub-module rs_mul_psel: a parameterized lowest-index priority selector with one-hot grant plus valid, instantiated twice (free-slot allocation and ready-issue select).

Test Plan:
1. Reset, then dispatch MUL with opa=3 and opb=5, both ready, mul_free=1 -> mul_enable pulses in cycle 2; rs_mul_packet opa=3, opb=5, func=ALU_MUL; entry freed.
2. Dispatch MULH with opb tag 7 unready; CDB broadcasts tag 7 value 0xFFFF_FFFE two cycles later -> issue the cycle after; packet opb=0xFFFF_FFFE.
3. Dispatch with opa tag 9 unready in the same cycle as a CDB broadcast of tag 9 value 11 -> entry captured ready; issue at cycle 2 with opa=11.
4. Fill 4 ready entries with mul_free=0 -> rs_mul_full=1; a 5th dispatch is ignored. Pulse mul_free -> entry 0 issues, full drops the next cycle, and rs_mul_packet holds while mul_free=0.
5. Two ready entries, mul_free held at 1 -> mul_enable pulses are never adjacent; entry 0 issues before entry 1.
6. Two pending entries; squash asserted together with dispatch_enable -> next cycle all valid=0, mul_enable=0, rs_mul_full=0; rs_mul_packet unchanged.
